// File: rtl/appx_mul_pkg.sv
// Shared types for the 8x8 approximate multiplier: partial-product matrix layout,
// occupancy states of the front-end buffer, and the truncation column mask.
package appx_mul_pkg;

  localparam int W_OP = 8;

  typedef logic [W_OP-1:0] pp_row_t;
  typedef pp_row_t [W_OP-1:0] pp_mat_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_t;

  // Bit [i][j] is kept when its weight i+j reaches the truncation threshold.
  function automatic pp_mat_t pp_mask(input int trunc);
    pp_mat_t m;
    m = '0;
    for (int i = 0; i < W_OP; i++) begin
      for (int j = 0; j < W_OP; j++) begin
        m[i][j] = ((i + j) >= trunc);
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/appx_pp_stage_if.sv
// Operand/partial-product handshake bundle between the operand source, the
// partial-product stage and the downstream compressor tree.
interface appx_pp_stage_if #(
  parameter int W = 8
);
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [W*W-1:0] pp_o;
  logic [1:0]     occ;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, pp_o, occ
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, pp_o, occ
  );
endinterface

// File: rtl/appx_pp_fifo2.sv
// Generic 2-entry register FIFO with valid/ready on both sides. The head register
// drives the output directly, so an accepted word is visible one edge later.
module appx_pp_fifo2
  import appx_mul_pkg::*;
#(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  occ_state_t        state, state_nxt;
  logic [DATA_W-1:0] head_p0;
  logic [DATA_W-1:0] tail_p0;
  logic              push, pop;
  logic              load_head, load_tail, head_from_tail;

  // Ready and valid come straight from state, never from the opposite side.
  assign in_ready  = (state != OCC_FULL);
  assign out_valid = (state != OCC_EMPTY);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign occ       = state;
  assign out_data  = head_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= OCC_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    load_head      = 1'b0;
    load_tail      = 1'b0;
    head_from_tail = 1'b0;
    case (state)
      OCC_EMPTY: begin
        if (push) begin
          state_nxt = OCC_ONE;
          load_head = 1'b1;
        end
      end
      OCC_ONE: begin
        // Simultaneous push/pop replaces the head in place: no bubble, no loss.
        if (push && pop) begin
          load_head = 1'b1;
        end else if (push) begin
          state_nxt = OCC_FULL;
          load_tail = 1'b1;
        end else if (pop) begin
          state_nxt = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (pop) begin
          state_nxt      = OCC_ONE;
          load_head      = 1'b1;
          head_from_tail = 1'b1;
        end
      end
      default: state_nxt = OCC_EMPTY;
    endcase
  end

  // ---- stage p0: head register (reset so the output reads zero after reset)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p0 <= '0;
    end else if (load_head) begin
      head_p0 <= head_from_tail ? tail_p0 : in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (load_tail) begin
      tail_p0 <= in_data;
    end
  end

endmodule

// File: rtl/appx_pp_stage.sv
// Front-end of the 8x8 approximate multiplier: AND partial-product array with
// optional low-column truncation, buffered into a 2-entry FIFO for the compressor tree.
module appx_pp_stage
  import appx_mul_pkg::*;
#(
  parameter int W     = 8,
  parameter int TRUNC = 0
) (
  input  logic            clk,
  input  logic            rst,
  appx_pp_stage_if.slave  bus
);

  localparam pp_mat_t MASK = pp_mask(TRUNC);

  pp_mat_t pp_raw;
  pp_mat_t pp_kept;

  always_comb begin
    pp_raw = '0;
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        pp_raw[i][j] = bus.a[j] & bus.b[i];
      end
    end
  end

  assign pp_kept = pp_raw & MASK;

  appx_pp_fifo2 #(
    .DATA_W (W * W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (pp_kept),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.pp_o),
    .occ       (bus.occ)
  );

endmodule

// File: tb/tb_appx_pp_stage.sv
// Scoreboard bench for appx_pp_stage: exact (TRUNC=0) and truncated (TRUNC=4) instances.
module tb_appx_pp_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  appx_pp_stage_if #(.W(8)) bus0 ();
  appx_pp_stage_if #(.W(8)) bus4 ();

  appx_pp_stage #(.W(8), .TRUNC(0)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
  appx_pp_stage #(.W(8), .TRUNC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int checks   = 0;
  int failures = 0;
  logic [63:0] q0[$];
  logic [63:0] q4[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitors: a transfer is seen at negedge and completes at the following posedge.
  always @(negedge clk) begin
    if (!rst && bus0.out_valid && bus0.out_ready) begin
      if (q0.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut0_unexpected_output actual=%h expected=none", bus0.pp_o);
      end else begin
        check("dut0_pp", bus0.pp_o, q0.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus4.out_valid && bus4.out_ready) begin
      if (q4.size() == 0) begin
        checks++; failures++;
        $display("FAIL dut4_unexpected_output actual=%h expected=none", bus4.pp_o);
      end else begin
        check("dut4_pp", bus4.pp_o, q4.pop_front());
      end
    end
  end

  task automatic send0(input logic [7:0] av, input logic [7:0] bv, input logic [63:0] exp);
    bus0.in_valid = 1'b1; bus0.a = av; bus0.b = bv;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus0.in_ready) begin
        q0.push_back(exp);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL dut0_accept_timeout actual=no_accept expected=accept a=%h", av);
    bus0.in_valid = 1'b0;
  endtask

  task automatic send4(input logic [7:0] av, input logic [7:0] bv, input logic [63:0] exp);
    bus4.in_valid = 1'b1; bus4.a = av; bus4.b = bv;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus4.in_ready) begin
        q4.push_back(exp);
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        return;
      end
    end
    checks++; failures++;
    $display("FAIL dut4_accept_timeout actual=no_accept expected=accept a=%h", av);
    bus4.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] wsum;
    rst = 1'b1;
    bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.a = '0; bus4.b = '0; bus4.out_ready = 1'b1;
    #12;
    check("reset_occ",       64'(bus0.occ),       64'd0);
    check("reset_out_valid", 64'(bus0.out_valid), 64'd0);
    check("reset_in_ready",  64'(bus0.in_ready),  64'd1);
    check("reset_pp",        bus0.pp_o,           64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single pair, exact matrix
    send0(8'hFF, 8'h01, 64'h0000_0000_0000_00FF);
    check("t1_out_valid", 64'(bus0.out_valid), 64'd1);
    check("t1_occ_one",   64'(bus0.occ),       64'd1);
    cycles(1);
    check("t1_occ_drain", 64'(bus0.occ),       64'd0);

    // Rows 0 and 7, plus column-weighted sum of the matrix
    send0(8'hA5, 8'h81, 64'hA500_0000_0000_00A5);
    wsum = 0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        if (bus0.pp_o[8*i+j]) wsum += (32'd1 << (i + j));
    check("t2_weighted_sum", 64'(wsum), 64'd21285);
    cycles(1);

    // Truncated instance: all-ones operands, then a product living only below the cut
    send4(8'hFF, 8'hFF, 64'hFFFF_FFFF_FEFC_F8F0);
    send4(8'h01, 8'h01, 64'h0);
    cycles(2);
    check("t3_queue_empty", 64'(q4.size()), 64'd0);

    // Back-pressure: two accepted, third held until occupancy drops
    bus0.out_ready = 1'b0;
    send0(8'h11, 8'h01, 64'h11);
    send0(8'h22, 8'h03, 64'h2222);
    check("t4_occ_full",  64'(bus0.occ),      64'd2);
    check("t4_not_ready", 64'(bus0.in_ready), 64'd0);
    bus0.in_valid = 1'b1; bus0.a = 8'h33; bus0.b = 8'h01;
    cycles(3);
    check("t4_still_full", 64'(bus0.occ),      64'd2);
    check("t4_still_busy", 64'(bus0.in_ready), 64'd0);
    check("t4_head_hold",  bus0.pp_o,          64'h11);
    bus0.out_ready = 1'b1;
    send0(8'h33, 8'h01, 64'h33);
    check("t4_occ_after_third", 64'(bus0.occ), 64'd1);
    cycles(2);
    check("t4_drained",    64'(bus0.occ),  64'd0);
    check("t4_queue_empty", 64'(q0.size()), 64'd0);

    // Streaming at occupancy one: accept and pop every cycle
    bus0.out_ready = 1'b0;
    send0(8'h40, 8'h01, 64'h40);
    bus0.out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      send0(8'h40 + 8'(k), 8'h01, 64'h40 + 64'(k));
      check("t5_occ_steady", 64'(bus0.occ), 64'd1);
    end
    cycles(2);
    check("t5_drained",     64'(bus0.occ),  64'd0);
    check("t5_queue_empty", 64'(q0.size()), 64'd0);

    // Asynchronous reset while full
    bus0.out_ready = 1'b0;
    send0(8'h55, 8'h01, 64'h55);
    send0(8'h66, 8'h01, 64'h66);
    check("t6_occ_full", 64'(bus0.occ), 64'd2);
    #2;
    rst = 1'b1;
    q0.delete();
    q4.delete();
    #1;
    check("t6_rst_out_valid", 64'(bus0.out_valid), 64'd0);
    check("t6_rst_occ",       64'(bus0.occ),       64'd0);
    check("t6_rst_in_ready",  64'(bus0.in_ready),  64'd1);
    check("t6_rst_pp",        bus0.pp_o,           64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus0.out_ready = 1'b1;
    send0(8'h77, 8'h01, 64'h77);
    cycles(2);
    check("t6_queue_empty", 64'(q0.size()), 64'd0);
    check("t6_occ_final",   64'(bus0.occ),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
